// File: rtl/fft16_sequencer_if.sv
// Stream and butterfly-bus bundle for the 16-point FFT sequencer.
// master = surrounding system (source, sink and butterfly), slave = sequencer.
interface fft16_sequencer_if #(parameter int DW = 17);
    logic [2*DW-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic [8*DW-1:0] bf_in;
    logic [23:0]     bf_rot;
    logic [8*DW-1:0] bf_out;

    modport master (
        output in_data, in_valid, out_ready, bf_out,
        input  in_ready, out_data, out_valid, out_last, busy, bf_in, bf_rot
    );
    modport slave (
        input  in_data, in_valid, out_ready, bf_out,
        output in_ready, out_data, out_valid, out_last, busy, bf_in, bf_rot
    );
endinterface

// File: rtl/fft16_sequencer.sv
// Load 16 samples, run two radix-4 stages in place through an external
// zero-latency butterfly, then stream results out in digit-reversed order.
module fft16_sequencer #(
    parameter int DW = 17
) (
    input logic               clk,
    input logic               rst_n,
    fft16_sequencer_if.slave  sif
);
    localparam int W = 2*DW;

    typedef enum logic [1:0] {LOAD, COMP1, COMP2, UNLOAD} state_t;

    state_t                state;
    logic [15:0][W-1:0]    bank;
    logic [3:0]            cnt;
    logic [1:0]            grp;
    logic                  in_ready_r, out_valid_r, out_last_r, busy_r;
    logic [3:0]            idx [4];
    logic [3:0][W-1:0]     bfi;
    logic [3:0][W-1:0]     bo;
    logic [7:0]            g8;
    logic                  comp;

    assign comp = (state == COMP1) || (state == COMP2);
    assign bo   = sif.bf_out;
    assign g8   = {6'd0, grp};

    // Stage 1 strides by 4 across the bank, stage 2 works on contiguous quads.
    always_comb begin
        bfi = '0;
        for (int k = 0; k < 4; k++) begin
            idx[k] = (state == COMP2) ? {grp, 2'(k)} : {2'(k), grp};
            if (comp) bfi[k] = bank[idx[k]];
        end
    end

    assign sif.bf_in     = bfi;
    assign sif.bf_rot    = (state == COMP2) ? {g8 * 8'd3, g8 * 8'd2, g8} : 24'd0;
    assign sif.out_data  = (state == UNLOAD) ? bank[{cnt[1:0], cnt[3:2]}] : '0;
    assign sif.in_ready  = in_ready_r;
    assign sif.out_valid = out_valid_r;
    assign sif.out_last  = out_last_r;
    assign sif.busy      = busy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            bank        <= '0;
            cnt         <= '0;
            grp         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (sif.in_valid && in_ready_r) begin
                        bank[cnt] <= sif.in_data;
                        cnt       <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state      <= COMP1;
                            grp        <= '0;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end
                    end
                end
                COMP1: begin
                    for (int k = 0; k < 4; k++) bank[idx[k]] <= bo[k];
                    grp <= grp + 2'd1;
                    if (grp == 2'd3) state <= COMP2;
                end
                COMP2: begin
                    for (int k = 0; k < 4; k++) bank[idx[k]] <= bo[k];
                    grp <= grp + 2'd1;
                    if (grp == 2'd3) begin
                        state       <= UNLOAD;
                        cnt         <= '0;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                    end
                end
                default: begin
                    if (sif.out_ready) begin
                        cnt        <= cnt + 4'd1;
                        out_last_r <= (cnt == 4'd14);
                        if (cnt == 4'd15) begin
                            state       <= LOAD;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
